// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a pipeline stage register with a valid/ready handshake.
// Two entries (main + skid) keep in_ready registered while still sustaining
// one word per cycle. The stage also supports a synchronous flush and counts
// stalled cycles in a saturating counter.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               FIELDS    = 2,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*FIELDS-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*FIELDS-1:0]   out_data,
  input  logic                      flush,
  output logic [CNT_WIDTH-1:0]      stall_cnt
);

  localparam int                   D        = WIDTH * FIELDS;
  localparam logic [D-1:0]         RST_WORD = {FIELDS{RST_VAL}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t       state;
  logic [D-1:0] main_q;
  logic [D-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = main_q;

  // Handshake FSM: moves words through main/skid and registers in_ready/out_valid.
  // NOTE: every register here uses non-blocking assignment, so all of the
  // branches read the pre-edge values of state, main_q and skid_q.
  // NOTE: main_q and skid_q are reset (they are only two words, not a memory).
  // The reset value is visible on out_data, so it must be defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_q    <= RST_WORD;
      skid_q    <= RST_WORD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      // Flush overrides everything else. Any word offered in this cycle is dropped.
      state     <= EMPTY;
      main_q    <= RST_WORD;
      skid_q    <= RST_WORD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q    <= in_data;
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            // Downstream is stalled. Park the new word in skid and close the input.
            skid_q   <= in_data;
            state    <= SKID;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= FULL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stall counter: counts cycles where a valid word is blocked. It saturates,
  // and only reset clears it (flush does not).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
